// File: rtl/seg_scan_driver_if.sv
// Bundle of the display-side signals for seg_scan_driver.
// The master drives the scan controls and the eight per-digit segment
// patterns. The slave (the scan driver) returns the multiplexed segment
// bus, the anode enables and the frame strobe.
interface seg_scan_driver_if;
   logic       en;
   logic       blank_lz;
   logic [6:0] seg1;
   logic [6:0] seg2;
   logic [6:0] seg3;
   logic [6:0] seg4;
   logic [6:0] seg5;
   logic [6:0] seg6;
   logic [6:0] seg7;
   logic [6:0] seg8;
   logic [6:0] seg_out;
   logic [7:0] an;
   logic       frame_done;

   modport master (
      output en, blank_lz,
      output seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8,
      input  seg_out, an, frame_done
   );

   modport slave (
      input  en, blank_lz,
      input  seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8,
      output seg_out, an, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A prescaler divides each digit slot into SCAN_DIV cycles. The first
// BLANK_CYC cycles of every slot keep all anodes dark, so one digit's pattern
// never bleeds into its neighbour. The eight segment patterns are copied into
// shadow registers once per frame, at slot 0 / count 0. The scan therefore
// never tears when the upstream decoder updates mid-frame. Optional
// leading-zero blanking suppresses the zero digits above the most
// significant non-zero digit. Digit 0 is always lit.
module seg_scan_driver #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_driver_if.slave   bus
);

   localparam int         CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [6:0] SEG_Z   = 7'b1000000;
   localparam logic [7:0] AN_OFF  = 8'hFF;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [6:0]       shadow_q [8];
   logic [6:0]       shadow_d [8];
   logic [6:0]       seg_out_q, seg_out_d;
   logic [7:0]       an_q, an_d;
   logic             frame_done_q, frame_done_d;

   logic [6:0]       seg_in [8];
   logic             tick;
   logic             capture;
   logic             lit;
   logic             all_zero;
   logic [7:0]       suppress;

   // Collect the per-digit inputs into an array indexed like the shadow regs.
   always_comb begin
      seg_in[0] = bus.seg1;
      seg_in[1] = bus.seg2;
      seg_in[2] = bus.seg3;
      seg_in[3] = bus.seg4;
      seg_in[4] = bus.seg5;
      seg_in[5] = bus.seg6;
      seg_in[6] = bus.seg7;
      seg_in[7] = bus.seg8;
   end

   // Prescaler and slot index. Dropping en parks the scan at slot 0 / count 0.
   always_comb begin
      cnt_d = cnt_q;
      idx_d = idx_q;
      tick  = bus.en && (cnt_q == CNT_W'(SCAN_DIV - 1));
      if (!bus.en) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         idx_d = idx_q + 3'd1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Frame capture: snapshot every pattern at the very start of a frame.
   always_comb begin
      capture = bus.en && (cnt_q == '0) && (idx_q == 3'd0);
      for (int k = 0; k < 8; k++) begin
         shadow_d[k] = capture ? seg_in[k] : shadow_q[k];
      end
   end

   // Leading-zero suppression: a digit is dark only if it and every higher digit are zero.
   always_comb begin
      all_zero = 1'b1;
      suppress = '0;
      for (int k = 7; k >= 1; k--) begin
         all_zero    = all_zero && (shadow_q[k] == SEG_Z);
         suppress[k] = bus.blank_lz && all_zero;
      end
      suppress[0] = 1'b0;
   end

   // Output decode for the current slot, registered below for one-cycle latency.
   always_comb begin
      lit          = bus.en && (cnt_q >= CNT_W'(BLANK_CYC)) && !suppress[idx_q];
      an_d         = AN_OFF;
      seg_out_d    = SEG_OFF;
      frame_done_d = tick && (idx_q == 3'd7);
      if (lit) begin
         an_d      = ~(8'b1 << idx_q);
         seg_out_d = shadow_q[idx_q];
      end
   end

   // Scan counters and shadow patterns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         idx_q <= '0;
         for (int k = 0; k < 8; k++) begin
            shadow_q[k] <= SEG_OFF;
         end
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         for (int k = 0; k < 8; k++) begin
            shadow_q[k] <= shadow_d[k];
         end
      end
   end

   // Registered display outputs. Reset forces the display dark immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q         <= AN_OFF;
         seg_out_q    <= SEG_OFF;
         frame_done_q <= 1'b0;
      end else begin
         an_q         <= an_d;
         seg_out_q    <= seg_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg_out    = seg_out_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4 and BLANK_CYC=1.
// Each frame is checked cycle by cycle against a per-slot table of
// {anode, segment} records. A record of FF/7F marks a slot that must stay dark.
module tb_seg_scan_driver;

   localparam int SCAN_DIV  = 4;
   localparam int BLANK_CYC = 1;

   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100;
   localparam logic [6:0] D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001;
   localparam logic [6:0] D5 = 7'b0010010;
   localparam logic [6:0] D6 = 7'b0000010;
   localparam logic [6:0] D7 = 7'b1111000;
   localparam logic [6:0] D8 = 7'b0000000;
   localparam logic [6:0] D9 = 7'b0010000;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
   } slot_vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   slot_vec_t curTbl [8];

   always #5 clk = ~clk;

   seg_scan_driver_if bus ();

   seg_scan_driver #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Drive the scan controls and all eight patterns; segs packs {seg8 .. seg1}.
   task automatic applyStimulus(input logic enV, input logic lzV, input logic [55:0] segs);
      bus.en       = enV;
      bus.blank_lz = lzV;
      bus.seg1     = segs[6:0];
      bus.seg2     = segs[13:7];
      bus.seg3     = segs[20:14];
      bus.seg4     = segs[27:21];
      bus.seg5     = segs[34:28];
      bus.seg6     = segs[41:35];
      bus.seg7     = segs[48:42];
      bus.seg8     = segs[55:49];
   endtask

   // Compare all outputs and confirm that at most one anode is active.
   task automatic checkOutput(input string name, input logic [7:0] expAn,
                              input logic [6:0] expSeg, input logic expFd);
      checks++;
      if (bus.an !== expAn) begin
         errors++;
         $display("[TB] FAIL %s an got %h expected %h", name, bus.an, expAn);
      end
      checks++;
      if (bus.seg_out !== expSeg) begin
         errors++;
         $display("[TB] FAIL %s seg_out got %b expected %b", name, bus.seg_out, expSeg);
      end
      checks++;
      if (bus.frame_done !== expFd) begin
         errors++;
         $display("[TB] FAIL %s frame_done got %b expected %b", name, bus.frame_done, expFd);
      end
      checks++;
      if ($countones(~bus.an) > 1) begin
         errors++;
         $display("[TB] FAIL %s onehot an got %h expected at most one low bit", name, bus.an);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Standard scan: digit N shows code N on anode N-1.
   task automatic loadScan();
      curTbl[0] = {8'hFE, D1};
      curTbl[1] = {8'hFD, D2};
      curTbl[2] = {8'hFB, D3};
      curTbl[3] = {8'hF7, D4};
      curTbl[4] = {8'hEF, D5};
      curTbl[5] = {8'hDF, D6};
      curTbl[6] = {8'hBF, D7};
      curTbl[7] = {8'h7F, D8};
   endtask

   // Check numCyc cycles of a frame that starts at slot 0 / count 0. At
   // count 1 of slot chgSlot, seg3 is rewritten to chgVal to probe tearing.
   task automatic checkFrame(input string tag, input int numCyc,
                             input int chgSlot, input logic [6:0] chgVal);
      int s;
      int c;
      for (int n = 0; n < numCyc; n++) begin
         s = n / SCAN_DIV;
         c = n % SCAN_DIV;
         step();
         if (c < BLANK_CYC) begin
            checkOutput($sformatf("%s s%0d c%0d", tag, s, c), 8'hFF, 7'h7F, n == 31);
         end else begin
            checkOutput($sformatf("%s s%0d c%0d", tag, s, c), curTbl[s].an, curTbl[s].seg, n == 31);
         end
         if (s == chgSlot && c == 1) begin
            bus.seg3 = chgVal;
         end
      end
   endtask

   initial begin
      logic [55:0] rnd;
      rnd = {$urandom, $urandom};
      applyStimulus(1'b1, rnd[0], rnd);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset", 8'hFF, 7'h7F, 1'b0);

      // Release with en high; first lit output is seg1 on an[0] at the second edge.
      applyStimulus(1'b1, 1'b0, {D8, D7, D6, D5, D4, D3, D2, D1});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      loadScan();
      checkFrame("scan0", 32, -1, 7'h00);
      checkFrame("scan1", 32, -1, 7'h00);

      // Tearing: seg3 edits mid-frame only show up after the next capture.
      bus.seg3 = D2;
      curTbl[2].seg = D2;
      checkFrame("tearA", 32, 5, D3);
      curTbl[2].seg = D3;
      checkFrame("tearB", 32, 1, D2);
      curTbl[2].seg = D2;
      checkFrame("tearC", 32, -1, 7'h00);

      // Leading-zero blanking on 00000042.
      applyStimulus(1'b1, 1'b1, {D0, D0, D0, D0, D0, D0, D2, D4});
      for (int k = 0; k < 8; k++) curTbl[k] = {8'hFF, 7'h7F};
      curTbl[0] = {8'hFE, D4};
      curTbl[1] = {8'hFD, D2};
      checkFrame("lz42", 32, -1, 7'h00);

      // All zeros: only the units digit remains.
      applyStimulus(1'b1, 1'b1, {D0, D0, D0, D0, D0, D0, D0, D0});
      curTbl[1] = {8'hFF, 7'h7F};
      curTbl[0] = {8'hFE, D0};
      checkFrame("lz0", 32, -1, 7'h00);

      // Blanking off: every zero digit is shown.
      bus.blank_lz = 1'b0;
      loadScan();
      for (int k = 0; k < 8; k++) curTbl[k].seg = D0;
      checkFrame("nolz0", 32, -1, 7'h00);

      // en drops on the slot-4 tick: dark from the next edge, and idx does not advance.
      applyStimulus(1'b1, 1'b0, {D8, D7, D6, D5, D4, D3, D2, D1});
      loadScan();
      checkFrame("predrop4", 19, -1, 7'h00);
      bus.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput($sformatf("enlow4 %0d", i), 8'hFF, 7'h7F, 1'b0);
      end
      bus.seg1 = D9;
      bus.en   = 1'b1;
      curTbl[0].seg = D9;
      checkFrame("restart4", 32, -1, 7'h00);

      // en drops exactly on the frame-ending tick: no frame_done pulse.
      checkFrame("predrop7", 31, -1, 7'h00);
      bus.en = 1'b0;
      step();
      checkOutput("enlow7", 8'hFF, 7'h7F, 1'b0);
      bus.en = 1'b1;
      checkFrame("restart7", 32, -1, 7'h00);

      // Async reset while slot 1 is lit: the display goes dark without a clock edge.
      checkFrame("prerst", 6, -1, 7'h00);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncrst", 8'hFF, 7'h7F, 1'b0);
      bus.seg2 = D7;
      curTbl[1].seg = D7;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkFrame("postrst", 32, -1, 7'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
